// File: rtl/voq_dequeue_ctrl_if.sv
// Enqueue, dequeue-request and packet-memory read signals of voq_dequeue_ctrl.
// The slave modport is the controller side; the master modport is the surrounding logic.
interface voq_dequeue_ctrl_if #(
  parameter int WIDX_W = 2
);
  logic              enq_valid;
  logic [1:0]        enq_voq;
  logic              enq_drop;
  logic [3:0]        voq_empty;
  logic              deq_valid;
  logic [1:0]        deq_voq;
  logic              deq_ready;
  logic              rd_en;
  logic [1:0]        rd_voq;
  logic [WIDX_W-1:0] rd_word;
  logic              rd_stall;
  logic              busy;

  modport slave (
    input  enq_valid, enq_voq, deq_ready, rd_stall,
    output enq_drop, voq_empty, deq_valid, deq_voq, rd_en, rd_voq, rd_word, busy
  );

  modport master (
    output enq_valid, enq_voq, deq_ready, rd_stall,
    input  enq_drop, voq_empty, deq_valid, deq_voq, rd_en, rd_voq, rd_word, busy
  );
endinterface

// File: rtl/voq_dequeue_ctrl.sv
// Occupancy counters for 4 VOQs plus a round-robin dequeue FSM that requests a grant
// and then streams one CELL_WORDS-word cell out of packet memory.
//
// state  | meaning
// S_IDLE | no cell in flight; pick a non-empty VOQ from the rotating pointer
// S_REQ  | deq_valid high, waiting for deq_ready on deq_voq
// S_XFER | issuing cell words to packet memory, one per non-stalled cycle
module voq_dequeue_ctrl #(
  parameter int CNT_W      = 6,
  parameter int CELL_WORDS = 4,
  parameter int WIDX_W     = 2
) (
  input logic               clk,
  input logic               rst_n,
  voq_dequeue_ctrl_if.slave q_if
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [WIDX_W-1:0] LAST_W  = WIDX_W'(CELL_WORDS - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q [4];
  logic [CNT_W-1:0]  cnt_d [4];
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [1:0]        deq_voq_q, deq_voq_d;
  logic [WIDX_W-1:0] wrem_q, wrem_d;
  logic              enq_drop_q, enq_drop_d;
  logic [3:0]        voq_empty_q, voq_empty_d;

  logic [3:0] nonzero;
  logic [7:0] nz_dbl;
  logic [3:0] nz_rot;
  logic [1:0] pick_off;
  logic [1:0] pick;
  logic       in_xfer;
  logic       rd_fire;
  logic       last_fire;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      nonzero[i] = (cnt_q[i] != '0);
    end
  end

  // Rotate the non-empty vector so bit 0 is the VOQ at rr_ptr, then take the first set bit.
  assign nz_dbl = {nonzero, nonzero};
  assign nz_rot = nz_dbl[rr_ptr_q +: 4];

  always_comb begin
    pick_off = 2'd3;
    if (nz_rot[0])      pick_off = 2'd0;
    else if (nz_rot[1]) pick_off = 2'd1;
    else if (nz_rot[2]) pick_off = 2'd2;
  end

  assign pick      = rr_ptr_q + pick_off;
  assign in_xfer   = (state_q == S_XFER);
  assign rd_fire   = in_xfer && !q_if.rd_stall;
  assign last_fire = rd_fire && (wrem_q == '0);

  // An enqueue landing on the VOQ that is freeing a cell this cycle nets to no change.
  always_comb begin
    enq_drop_d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic inc;
      logic dec;
      inc      = q_if.enq_valid && (q_if.enq_voq == 2'(i));
      dec      = last_fire && (deq_voq_q == 2'(i));
      cnt_d[i] = cnt_q[i];
      if (inc && !dec) begin
        if (cnt_q[i] != CNT_MAX) begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end else begin
          enq_drop_d = 1'b1;
        end
      end else if (dec && !inc) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
      voq_empty_d[i] = (cnt_d[i] == '0);
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    deq_voq_d = deq_voq_q;
    wrem_d    = wrem_q;
    unique case (state_q)
      S_IDLE: begin
        if (|nonzero) begin
          deq_voq_d = pick;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (q_if.deq_ready) begin
          wrem_d  = LAST_W;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (rd_fire) begin
          if (wrem_q == '0) begin
            rr_ptr_d = deq_voq_q + 2'd1;
            state_d  = S_IDLE;
          end else begin
            wrem_d = wrem_q - 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= 2'd0;
      deq_voq_q   <= 2'd0;
      wrem_q      <= '0;
      enq_drop_q  <= 1'b0;
      voq_empty_q <= 4'hF;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      deq_voq_q   <= deq_voq_d;
      wrem_q      <= wrem_d;
      enq_drop_q  <= enq_drop_d;
      voq_empty_q <= voq_empty_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Word index counts up while the remaining-words timer counts down to its terminal value.
  assign q_if.enq_drop  = enq_drop_q;
  assign q_if.voq_empty = voq_empty_q;
  assign q_if.deq_valid = (state_q == S_REQ);
  assign q_if.deq_voq   = deq_voq_q;
  assign q_if.rd_en     = rd_fire;
  assign q_if.rd_voq    = in_xfer ? deq_voq_q : 2'd0;
  assign q_if.rd_word   = in_xfer ? (LAST_W - wrem_q) : '0;
  assign q_if.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_voq_dequeue_ctrl.sv
// Scoreboard bench for voq_dequeue_ctrl: directed scenarios followed by random traffic,
// all checked against a queue/array reference model of the occupancy and service rules.
module tb_voq_dequeue_ctrl;
  localparam int CNT_W  = 2;
  localparam int CW     = 4;
  localparam int WIDX_W = 2;
  localparam int MAXC   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  voq_dequeue_ctrl_if #(.WIDX_W(WIDX_W)) q_if ();

  voq_dequeue_ctrl #(.CNT_W(CNT_W), .CELL_WORDS(CW), .WIDX_W(WIDX_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .q_if (q_if)
  );

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endfunction

  // Reference model: per-VOQ counts, pointer, and an abstract phase 0=idle 1=request 2=transfer
  int m_cnt [4];
  int m_ptr, m_phase, m_cur, m_word;
  bit m_drop;
  int hs_q[$];
  int rd_q[$];
  int served[$];
  int drop_seen;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_ptr = 0; m_phase = 0; m_cur = 0; m_word = 0; m_drop = 1'b0;
      hs_q.delete();
      rd_q.delete();
    end else begin : step
      int old [4];
      bit dec;
      bit found;
      int v;
      old   = m_cnt;
      dec   = 1'b0;
      found = 1'b0;
      case (m_phase)
        0: begin
          for (int k = 0; k < 4; k++) begin
            if (!found && old[(m_ptr + k) % 4] > 0) begin
              m_cur = (m_ptr + k) % 4;
              found = 1'b1;
            end
          end
          if (found) begin
            m_phase = 1;
            hs_q.push_back(m_cur);
          end
        end
        1: begin
          if (q_if.deq_ready) begin
            m_phase = 2;
            m_word  = 0;
            for (int w = 0; w < CW; w++) rd_q.push_back(m_cur * 16 + w);
          end
        end
        default: begin
          if (!q_if.rd_stall) begin
            if (m_word == CW - 1) begin
              dec     = 1'b1;
              m_ptr   = (m_cur + 1) % 4;
              m_phase = 0;
            end else begin
              m_word++;
            end
          end
        end
      endcase
      m_drop = 1'b0;
      if (dec) m_cnt[m_cur]--;
      if (q_if.enq_valid) begin
        v = int'(q_if.enq_voq);
        if (old[v] == MAXC && !(dec && m_cur == v)) m_drop = 1'b1;
        else m_cnt[v]++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin : mon
      logic [3:0] e_empty;
      int e;
      for (int i = 0; i < 4; i++) e_empty[i] = (m_cnt[i] == 0);
      chk("voq_empty", int'(q_if.voq_empty), int'(e_empty));
      chk("enq_drop", int'(q_if.enq_drop), int'(m_drop));
      chk("busy", int'(q_if.busy), int'(m_phase != 0));
      chk("deq_valid", int'(q_if.deq_valid), int'(m_phase == 1));
      chk("rd_en", int'(q_if.rd_en), int'(m_phase == 2 && !q_if.rd_stall));
      if (q_if.enq_drop) drop_seen++;
      if (q_if.deq_valid && q_if.deq_ready) begin
        if (hs_q.size() == 0) chk("hs_unexpected", 1, 0);
        else begin
          e = hs_q.pop_front();
          chk("deq_voq", int'(q_if.deq_voq), e);
          served.push_back(int'(q_if.deq_voq));
        end
      end
      if (q_if.rd_en) begin
        if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          e = rd_q.pop_front();
          chk("rd_voq", int'(q_if.rd_voq), e / 16);
          chk("rd_word", int'(q_if.rd_word), e % 16);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    q_if.enq_valid = 1'b0;
    q_if.enq_voq   = 2'd0;
    q_if.deq_ready = 1'b0;
    q_if.rd_stall  = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic enq(input int voq);
    q_if.enq_valid = 1'b1;
    q_if.enq_voq   = 2'(voq);
    tick();
    q_if.enq_valid = 1'b0;
  endtask

  task automatic wait_word(input int w, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 60 && !ok; c++) begin
      tick();
      if (q_if.rd_en && int'(q_if.rd_word) == w) ok = 1'b1;
    end
    chk("wait_word_timeout", int'(ok), 1);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    q_if.enq_valid = 1'b0;
    q_if.deq_ready = 1'b1;
    q_if.rd_stall  = 1'b0;
    for (int c = 0; c < 500 && !ok; c++) begin
      tick();
      if (q_if.voq_empty == 4'hF && !q_if.busy) ok = 1'b1;
    end
    chk("drain_timeout", int'(ok), 1);
  endtask

  initial begin : main
    bit ok;
    int exp_rr [6];
    int xc, st;
    bit stalled, done;
    exp_rr = '{0, 1, 3, 0, 1, 3};

    do_reset();
    chk("rst_voq_empty", int'(q_if.voq_empty), 15);
    chk("rst_busy", int'(q_if.busy), 0);
    chk("rst_deq_valid", int'(q_if.deq_valid), 0);

    // Single cell on VOQ2 with the expected two-cycle request latency
    q_if.deq_ready = 1'b1;
    enq(2);
    chk("lat_t1_deq_valid", int'(q_if.deq_valid), 0);
    tick();
    chk("lat_t2_deq_valid", int'(q_if.deq_valid), 1);
    chk("lat_t2_deq_voq", int'(q_if.deq_voq), 2);
    for (int w = 0; w < CW; w++) begin
      tick();
      chk("single_rd_en", int'(q_if.rd_en), 1);
      chk("single_rd_word", int'(q_if.rd_word), w);
    end
    tick();
    chk("single_empty_after", int'(q_if.voq_empty), 15);

    // Pointer advanced past VOQ1: later arrivals on 0 and 3 are served 3 then 0
    served.delete();
    enq(1);
    enq(0);
    enq(3);
    drain();
    chk("ptr_served_n", served.size(), 3);
    if (served.size() == 3) begin
      chk("ptr_order0", served[0], 1);
      chk("ptr_order1", served[1], 3);
      chk("ptr_order2", served[2], 0);
    end

    // Async reset in the middle of a transfer
    enq(2);
    wait_word(1, ok);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_rd_en", int'(q_if.rd_en), 0);
    chk("abort_busy", int'(q_if.busy), 0);
    chk("abort_deq_valid", int'(q_if.deq_valid), 0);
    chk("abort_rd_word", int'(q_if.rd_word), 0);
    chk("abort_rd_voq", int'(q_if.rd_voq), 0);
    chk("abort_deq_voq", int'(q_if.deq_voq), 0);
    chk("abort_voq_empty", int'(q_if.voq_empty), 15);
    chk("abort_enq_drop", int'(q_if.enq_drop), 0);
    do_reset();

    // Round robin with wrap
    served.delete();
    foreach (exp_rr[i]) enq(exp_rr[i]);
    drain();
    chk("rr_served_n", served.size(), 6);
    if (served.size() == 6) foreach (exp_rr[i]) chk("rr_order", served[i], exp_rr[i]);

    // Saturation, then an enqueue landing on the final word of the saturated VOQ
    do_reset();
    served.delete();
    drop_seen = 0;
    repeat (4) enq(1);
    tick();
    tick();
    chk("sat_drops", drop_seen, 1);
    q_if.deq_ready = 1'b1;
    wait_word(CW - 1, ok);
    q_if.enq_valid = 1'b1;
    q_if.enq_voq   = 2'd1;
    tick();
    q_if.enq_valid = 1'b0;
    chk("sat_final_empty1", int'(q_if.voq_empty[1]), 0);
    drain();
    chk("sat_drops_after", drop_seen, 1);
    chk("sat_cells", served.size(), 4);

    // Grant backpressure then read stall on word 1
    do_reset();
    enq(0);
    tick();
    for (int c = 0; c < 10; c++) begin
      chk("hold_deq_valid", int'(q_if.deq_valid), 1);
      chk("hold_deq_voq", int'(q_if.deq_voq), 0);
      tick();
    end
    q_if.deq_ready = 1'b1;
    xc = 0; st = 0; stalled = 1'b0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      tick();
      if (st > 0) begin
        st--;
        if (st == 0) q_if.rd_stall = 1'b0;
      end else if (!stalled && q_if.rd_en && q_if.rd_word == 2'd1) begin
        q_if.rd_stall = 1'b1;
        stalled = 1'b1;
        st = 3;
      end
      #1;
      if (st > 0) begin
        chk("stall_rd_en", int'(q_if.rd_en), 0);
        chk("stall_rd_word", int'(q_if.rd_word), 1);
      end
      if (q_if.busy && !q_if.deq_valid) xc++;
      if (xc > 0 && !q_if.busy) done = 1'b1;
    end
    chk("stall_done", int'(done), 1);
    chk("stall_xfer_cycles", xc, 7);
    drain();

    // Random traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      q_if.enq_valid = 1'($urandom_range(0, 1));
      q_if.enq_voq   = 2'($urandom_range(0, 3));
      q_if.deq_ready = ($urandom_range(0, 3) != 0);
      q_if.rd_stall  = ($urandom_range(0, 3) == 0);
      tick();
    end
    drain();
    tick();
    chk("end_hs_left", hs_q.size(), 0);
    chk("end_rd_left", rd_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
